// File: rtl/i2c_cmd_sched.sv
// Schedules host commands and settled reverb-parameter refreshes onto one valid/ready DSP core bus.
// Commands win over parameters; optional bus_ready wait limit under `CMD_TIMEOUT_EN.
module i2c_cmd_sched #(
  parameter int N_CORES     = 4,
  parameter int REVERB_CORE = 0,
  parameter int SETTLE_CYC  = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic         mclk,
  input  logic         reset,
  input  logic [255:0] i2c_mem,
  output logic         bus_valid,
  input  logic         bus_ready,
  output logic [3:0]   bus_core,
  output logic [2:0]   bus_op,
  output logic [15:0]  bus_addr,
  output logic [15:0]  bus_data,
  output logic         busy,
  output logic         cmd_done,
  output logic         cmd_err,
  output logic [7:0]   cmd_count
);

  localparam int SW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, CMD_ISSUE, PARAM_ISSUE} state_t;

  state_t           state, state_nxt;
  logic             last_toggle, last_toggle_nxt;
  logic [3:0][15:0] shadow, shadow_nxt;
  logic [1:0]       pidx, pidx_nxt;
  logic             valid_nxt, done_nxt, err_nxt;
  logic [3:0]       core_nxt;
  logic [2:0]       op_nxt;
  logic [15:0]      addr_nxt, data_nxt;
  logic [7:0]       count_nxt;

  logic [7:0]       byte0;
  logic [95:0]      cfg, cfg_prev;
  logic [SW-1:0]    settle_cnt;
  logic             cfg_stable, settled, pending, cmd_bad;
  logic [3:0][15:0] live_param;
  logic             elig_any;
  logic [1:0]       elig_idx;
  logic             wait_expired;
  logic             unused_mem;

  assign byte0      = i2c_mem[7:0];
  assign cfg        = i2c_mem[103:8];
  assign unused_mem = ^i2c_mem[255:104];
  assign cfg_stable = (cfg == cfg_prev);
  // The cycle a byte changes counts as unsettled even before the counter clears.
  assign settled    = cfg_stable && (settle_cnt == SW'(SETTLE_CYC));
  assign pending    = (byte0[7] != last_toggle);
  assign cmd_bad    = (byte0[6:5] == 2'b11) || (32'(byte0[3:0]) >= N_CORES);
  assign busy       = pending || (state == CMD_ISSUE);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      live_param[k] = {i2c_mem[8*(5+2*k) +: 8], i2c_mem[8*(6+2*k) +: 8]};
    end
  end

  always_comb begin
    elig_any = 1'b0;
    elig_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (settled && (live_param[k] != shadow[k])) begin
        elig_any = 1'b1;
        elig_idx = 2'(k);
      end
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge mclk) begin
    if (reset || state == IDLE) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  assign wait_expired = (wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    last_toggle_nxt = last_toggle;
    shadow_nxt      = shadow;
    pidx_nxt        = pidx;
    valid_nxt       = bus_valid;
    core_nxt        = bus_core;
    op_nxt          = bus_op;
    addr_nxt        = bus_addr;
    data_nxt        = bus_data;
    done_nxt        = 1'b0;
    err_nxt         = 1'b0;
    count_nxt       = cmd_count;
    case (state)
      IDLE: begin
        if (pending) begin
          last_toggle_nxt = byte0[7];
          if (cmd_bad) begin
            err_nxt = 1'b1;
          end else if (byte0[6:4] == 3'd0) begin
            done_nxt  = 1'b1;
            count_nxt = cmd_count + 8'd1;
          end else begin
            valid_nxt = 1'b1;
            core_nxt  = byte0[3:0];
            op_nxt    = byte0[6:4];
            addr_nxt  = {i2c_mem[15:8], i2c_mem[23:16]};
            data_nxt  = {i2c_mem[31:24], i2c_mem[39:32]};
            state_nxt = CMD_ISSUE;
          end
        end else if (elig_any) begin
          valid_nxt = 1'b1;
          core_nxt  = 4'(REVERB_CORE);
          op_nxt    = 3'd7;
          addr_nxt  = {14'd0, elig_idx};
          data_nxt  = live_param[elig_idx];
          pidx_nxt  = elig_idx;
          state_nxt = PARAM_ISSUE;
        end
      end
      CMD_ISSUE: begin
        if (bus_ready) begin
          valid_nxt = 1'b0;
          done_nxt  = 1'b1;
          count_nxt = cmd_count + 8'd1;
          state_nxt = IDLE;
        end else if (wait_expired) begin
          valid_nxt = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      PARAM_ISSUE: begin
        // The snapshot is recorded either way so a timed-out value is not retried.
        if (bus_ready || wait_expired) begin
          valid_nxt        = 1'b0;
          err_nxt          = !bus_ready;
          shadow_nxt[pidx] = bus_data;
          state_nxt        = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state       <= IDLE;
      last_toggle <= 1'b0;
      shadow      <= '0;
      pidx        <= 2'd0;
      bus_valid   <= 1'b0;
      bus_core    <= 4'd0;
      bus_op      <= 3'd0;
      bus_addr    <= 16'd0;
      bus_data    <= 16'd0;
      cmd_done    <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_count   <= 8'd0;
      cfg_prev    <= cfg;
      settle_cnt  <= '0;
    end else begin
      state       <= state_nxt;
      last_toggle <= last_toggle_nxt;
      shadow      <= shadow_nxt;
      pidx        <= pidx_nxt;
      bus_valid   <= valid_nxt;
      bus_core    <= core_nxt;
      bus_op      <= op_nxt;
      bus_addr    <= addr_nxt;
      bus_data    <= data_nxt;
      cmd_done    <= done_nxt;
      cmd_err     <= err_nxt;
      cmd_count   <= count_nxt;
      cfg_prev    <= cfg;
      if (!cfg_stable)                          settle_cnt <= '0;
      else if (settle_cnt != SW'(SETTLE_CYC))   settle_cnt <= settle_cnt + 1'b1;
    end
  end

endmodule

// File: doc/i2c_cmd_sched.md
Name: i2c_cmd_sched

Overview:
- Command scheduler sitting behind the I2C configuration register file.
- Decodes the host command block (bytes 0-4) and the four 16-bit reverb parameters (bytes 5-12) out of the flat 256-bit register image.
- Issues them as single-beat transactions on one shared valid/ready DSP core bus.
- Arbitrates between host commands and reverb-parameter refreshes. Commands take priority; parameters are sent lowest index first.

Parameters:
N_CORES, 4, number of DSP cores addressable; legal core select range is 0..N_CORES-1.
REVERB_CORE, 0, core index driven on bus_core for parameter writes.
SETTLE_CYC, 64, cycles bytes 1-12 must stay unchanged before a parameter refresh is eligible.
TIMEOUT_CYC, 1024, bus_ready wait limit in cycles; used only with CMD_TIMEOUT_EN.

Ports:
mclk  in  1  system clock.
reset  in  1  synchronous reset, active-high.
i2c_mem  in  256  register image; byte k = i2c_mem[8k+7:8k].
bus_valid  out  1  transaction valid.
bus_ready  in  1  core accepts the transaction.
bus_core  out  4  target core.
bus_op  out  3  operation code.
bus_addr  out  16  address, or parameter index.
bus_data  out  16  write data.
busy  out  1  command pending or in flight.
cmd_done  out  1  one-cycle pulse: command finished OK.
cmd_err  out  1  one-cycle pulse: command rejected or timed out.
cmd_count  out  8  count of completed commands; wraps 255->0.

Behaviour:
- Interface is decided: one clock, mclk. Reset is synchronous and active-high. All state changes on posedge mclk only.
- Reset values:
  - All outputs are 0.
  - Internal state: last_toggle=0, shadow params all 0, settle counter 0, FSM in IDLE.
- Reset mid-transaction drops bus_valid at that edge with no handshake. Any nonzero parameters are therefore re-sent after reset.
- Byte 0 (command byte):
  - bit7 is the go toggle.
  - bits[6:4] are the opcode.
  - bits[3:0] are the core select.
- Opcodes:
  - 0 NOP
  - 1 PM_WRITE
  - 2 DM_WRITE
  - 3 START
  - 4 STOP
  - 5 CORE_RESET
  - 6, 7 illegal
- Operand mapping: addr = {byte1, byte2}, data = {byte3, byte4}.
- Parameter k (k = 0..3) = {byte(5+2k), byte(6+2k)}, high byte first.
- Pending command: byte0[7] != last_toggle.
- Command latching:
  - A command is latched only in IDLE. At latch, last_toggle <= byte0[7] and bytes 0-4 are captured.
  - The host writes bytes 1-4 before byte 0 and polls busy before the next toggle. Two toggles before latch cancel each other (not an error).
- busy = pending OR FSM in CMD_ISSUE.
- Settle counter:
  - Clears whenever bytes 1-12 differ from their previous-cycle copy.
  - Otherwise increments, saturating at SETTLE_CYC.
  - Param k is eligible when live value != shadow[k] and the counter is saturated.
- FSM states:
  - IDLE, with the following priority:
    - (1) Pending command with opcode 6/7, or core select >= N_CORES: cmd_err pulses on the next cycle, stays in IDLE, no bus activity.
    - (2) Pending NOP: cmd_done pulses next cycle, cmd_count+1, no bus activity.
    - (3) Other pending command: load bus fields, bus_valid=1 next cycle, go to CMD_ISSUE.
    - (4) Otherwise, lowest eligible k: bus_op=7, bus_core=REVERB_CORE, bus_addr=k, bus_data=snapshot; go to PARAM_ISSUE.
  - CMD_ISSUE:
    - Hold bus_valid and all bus fields stable until bus_valid && bus_ready.
    - At the handshake edge: bus_valid<=0, cmd_done pulses the following cycle, cmd_count+1, return to IDLE.
  - PARAM_ISSUE:
    - Same hold rule as CMD_ISSUE.
    - On handshake: shadow[k] <= snapshot (not the live value), return to IDLE.
    - A live change during issue is caught as a new mismatch later.
- Latency: toggle written at cycle t gives bus_valid high at t+1, since IDLE detects it combinationally from the stable image.
- A command arriving during PARAM_ISSUE waits. The parameter is not preempted.
- Back-to-back transactions: there is at least one IDLE cycle between them, so bus_valid is low for ≥1 cycle between transactions.
- bus_ready asserted while bus_valid=0 is ignored.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A wait counter runs in CMD_ISSUE/PARAM_ISSUE.
  - If it reaches TIMEOUT_CYC without a handshake: bus_valid<=0, cmd_err pulses, return to IDLE, cmd_count unchanged.
  - For a parameter timeout, shadow[k] <= snapshot so the same value is not retried.
- Undefined: the block waits indefinitely for bus_ready. No wait counter is synthesised.

Test Plan:
1. Bytes1-4=12,34,AB,CD, then byte0=0x91 -> next cycle bus_valid=1, core=1, op=1, addr=0x1234, data=0xABCD; hold ready low 5 cycles with fields stable; ready=1 -> cmd_done pulse, cmd_count=1, busy=0.
2. byte0=0xE0 (opcode 6), then byte0=0x47 with N_CORES=4 (toggle back to 0, core 7) -> two cmd_err pulses, no bus_valid, cmd_count unchanged.
3. Param1=0x0800 written with bus_ready=1 -> no bus_valid for 64 cycles; then op=7, addr=1, data=0x0800 once; no repeat afterward.
4. Param0 and param2 changed plus a command toggled in the same settled window -> command issued first, then param0, then param2, each separated by ≥1 idle cycle.
5. reset=1 for one cycle while bus_valid=1 awaits ready, params nonzero -> outputs 0 at next edge; after SETTLE_CYC all nonzero params re-sent.
6. (CMD_TIMEOUT_EN, TIMEOUT_CYC=16) START command with bus_ready tied 0 -> bus_valid drops after 16 cycles, cmd_err pulse, busy=0, cmd_count unchanged.
